uart_rx: RTL and testbench
==========================

UART_RX -- requirements
Module: uart_rx

Interface
REQ-001 SHALL have parameter CLK_FREQ, default 99_800_000, clock frequency in Hz.
REQ-002 SHALL have parameter BAUD, default 115200, line bit rate.
REQ-003 SHALL derive DIV = round(CLK_FREQ/BAUD) (866 at defaults) and HALF = DIV/2 truncated (433); DIV >= 4 required.
REQ-004 clk  input  1  sole clock, all logic rising-edge.
REQ-005 sys_resetn  input  1  reset, asynchronous, active-low.
REQ-006 uart_rxp  input  1  serial line, asynchronous to clk, idle high, 8N1, LSB first.
REQ-007 dout  output  8  received byte.
REQ-008 dout_valid  output  1  dout holds an unconsumed byte.
REQ-009 dout_ready  input  1  consumer accepts byte when high with dout_valid.
REQ-010 frame_err  output  1  one-cycle pulse: stop bit sampled low.
REQ-011 break_det  output  1  one-cycle pulse: all data bits and the stop bit sampled low.
REQ-012 overrun  output  1  sticky: a byte was dropped because the buffer was full.
REQ-013 clr_err  input  1  synchronous clear of overrun.

Function
REQ-014 uart_rxp SHALL pass through a 2-flop synchronizer; rx_s denotes its output. All timing below is counted from rx_s.
REQ-015 States: IDLE, START, DATA, STOP, WAIT_HIGH. One bit counter (0..DIV-1) and one 3-bit data index.
REQ-016 IDLE: a 1->0 transition on rx_s SHALL enter START with counter 0.
REQ-017 START: at counter == HALF-1, rx_s high -> glitch, return to IDLE, no output. rx_s low -> enter DATA with counter 0, index 0.
REQ-018 DATA: at counter == DIV-1, sample rx_s into shift bit [index]. The counter resets to 0. After index 7 the block enters STOP.
REQ-019 STOP: at counter == DIV-1, sample rx_s.
- Sample high: the byte completes. Return to IDLE.
- Sample low, byte nonzero: pulse frame_err, discard the byte, go to WAIT_HIGH.
- Sample low, byte == 0x00: pulse break_det only (no frame_err), discard the byte, go to WAIT_HIGH.
REQ-020 WAIT_HIGH: remain until rx_s == 1, then go to IDLE. A falling edge is not accepted until the block is in IDLE.
REQ-021 Byte completion SHALL load dout and set dout_valid on the clock edge after the stop-bit sample cycle (1-cycle latency).
REQ-022 Handshake: dout_valid high and dout_ready high at a rising edge -> dout_valid clears on that edge. dout holds its value while valid.
REQ-023 Completion while dout_valid is high and dout_ready is low SHALL drop the new byte, keep the old dout, and set overrun.
REQ-024 Completion in the same cycle as a handshake SHALL load the new byte, keep dout_valid high, and leave overrun unchanged.
REQ-025 clr_err clears overrun. If clr_err coincides with a new overrun event, set takes priority.
REQ-026 Counter widths SHALL cover DIV-1 with no wrap. Bit-center drift over a frame SHALL stay below ±DIV/2 for a baud error up to 2%.
REQ-027 The receiver SHALL run independently of dout_ready. Reception is never stalled.

Reset
REQ-028 While sys_resetn is low:
- state = IDLE, counters = 0.
- Both synchronizer flops = 1.
- dout = 0x00, dout_valid = 0, frame_err = 0, break_det = 0, overrun = 0.
REQ-029 Reset asserted mid-frame SHALL abandon the frame with no output. After release, a line held low SHALL NOT start a frame until a 1->0 transition is seen.

Verification (bench parameters CLK_FREQ=16, BAUD=1 -> DIV=16, HALF=8)
REQ-030 Send 0x55 with a valid stop bit, dout_ready held high.
- Expected: dout = 0x55, dout_valid high exactly 1 cycle.
- Expected: frame_err = 0, overrun = 0.
REQ-031 Hold uart_rxp low for 5 cycles, then return it high.
- Expected: no dout_valid.
- Expected: state back in IDLE, then 0xA3 received correctly.
REQ-032 Send 0x3C with the stop bit low.
- Expected: frame_err pulses 1 cycle, no dout_valid.
- Expected: next 0x81 accepted after the line returns high.
REQ-033 Hold the line low for 12 bit times.
- Expected: break_det pulses once, frame_err stays 0.
- Expected: no byte until the line goes high, then 0xFF received.
REQ-034 dout_ready = 0; send 0x11 then 0x22.
- Expected: dout stays 0x11, overrun = 1.
- Expected: after clr_err, overrun = 0. Handshake then clears dout_valid.
- Repeat with dout_ready pulsed in 0x22's completion cycle: dout = 0x22, dout_valid stays 1, overrun stays 0.
REQ-035 Assert sys_resetn low during DATA bit 4 of 0xF0.
- Expected: all outputs take reset values immediately.
- Expected: no byte after release, then 0x5A received correctly.

Source files
------------

// File: rtl/uart_rx_if.sv
// Byte-side bus of the UART receiver: received byte handshake plus error/status flags.
// master = receiver side, slave = consumer side.
interface uart_rx_if;
  logic [7:0] dout;
  logic       dout_valid;
  logic       dout_ready;
  logic       frame_err;
  logic       break_det;
  logic       overrun;
  logic       clr_err;

  modport master (
    output dout, dout_valid, frame_err, break_det, overrun,
    input  dout_ready, clr_err
  );

  modport slave (
    input  dout, dout_valid, frame_err, break_det, overrun,
    output dout_ready, clr_err
  );
endinterface

// File: rtl/uart_rx.sv
// 8N1 UART receiver: mid-bit sampling from a falling-edge-aligned bit counter,
// one-byte output buffer with valid/ready handshake, frame/break/overrun reporting.
module uart_rx #(
  parameter int CLK_FREQ = 99_800_000,
  parameter int BAUD     = 115200
) (
  input  logic       clk,
  input  logic       sys_resetn,
  input  logic       uart_rxp,
  uart_rx_if.master  bus,
  output logic [2:0] fsm_state
);
  localparam int DIV  = (CLK_FREQ + BAUD / 2) / BAUD;
  localparam int HALF = DIV / 2;
  localparam int CW   = $clog2(DIV);
  localparam logic [CW-1:0] DIV_M1  = CW'(DIV - 1);
  localparam logic [CW-1:0] HALF_M1 = CW'(HALF - 1);

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_START     = 3'd1,
    S_DATA      = 3'd2,
    S_STOP      = 3'd3,
    S_WAIT_HIGH = 3'd4
  } state_t;

  state_t        state, state_next;
  logic          sync1, rx_s, rx_prev;
  logic [1:0]    fill;
  logic [CW-1:0] cnt;
  logic [2:0]    idx;
  logic [7:0]    shreg;
  logic          fall, bit_end, sample_bit, done, ferr_evt, brk_evt;

  // Synchronizer flops reset high; rx_prev is masked until the pipeline holds real
  // line samples so a line already low at reset release is never taken as an edge.
  always_ff @(posedge clk or negedge sys_resetn) begin
    if (!sys_resetn) begin
      sync1   <= 1'b1;
      rx_s    <= 1'b1;
      rx_prev <= 1'b0;
      fill    <= 2'b00;
    end else begin
      sync1   <= uart_rxp;
      rx_s    <= sync1;
      fill    <= {fill[0], 1'b1};
      rx_prev <= fill[1] ? rx_s : 1'b0;
    end
  end

  assign fall    = rx_prev & ~rx_s;
  assign bit_end = (cnt == DIV_M1);

  always_ff @(posedge clk or negedge sys_resetn) begin
    if (!sys_resetn) state <= S_IDLE;
    else             state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      S_IDLE:      if (fall) state_next = S_START;
      S_START:     if (cnt == HALF_M1) state_next = rx_s ? S_IDLE : S_DATA;
      S_DATA:      if (bit_end && idx == 3'd7) state_next = S_STOP;
      S_STOP:      if (bit_end) state_next = rx_s ? S_IDLE : S_WAIT_HIGH;
      S_WAIT_HIGH: if (rx_s) state_next = S_IDLE;
      default:     state_next = S_IDLE;
    endcase
  end

  always_comb begin
    sample_bit = 1'b0;
    done       = 1'b0;
    ferr_evt   = 1'b0;
    brk_evt    = 1'b0;
    fsm_state  = state;
    if (state == S_DATA && bit_end) sample_bit = 1'b1;
    if (state == S_STOP && bit_end) begin
      done     = rx_s;
      ferr_evt = ~rx_s && (shreg != 8'h00);
      brk_evt  = ~rx_s && (shreg == 8'h00);
    end
  end

  // Bit counter restarts on every state change, so each phase is timed from its own entry.
  always_ff @(posedge clk or negedge sys_resetn) begin
    if (!sys_resetn) begin
      cnt   <= '0;
      idx   <= 3'd0;
      shreg <= 8'h00;
    end else begin
      if (state_next != state)
        cnt <= '0;
      else if (state == S_START || state == S_DATA || state == S_STOP)
        cnt <= bit_end ? '0 : cnt + 1'b1;

      if (state == S_START)
        idx <= 3'd0;
      else if (sample_bit) begin
        shreg[idx] <= rx_s;
        idx        <= idx + 3'd1;
      end
    end
  end

  // Handshake: a byte transfers on any edge where dout_valid and dout_ready are both high.
  // A completed byte is accepted whenever the buffer is empty or being drained this edge.
  always_ff @(posedge clk or negedge sys_resetn) begin
    if (!sys_resetn) begin
      bus.dout       <= 8'h00;
      bus.dout_valid <= 1'b0;
      bus.overrun    <= 1'b0;
      bus.frame_err  <= 1'b0;
      bus.break_det  <= 1'b0;
    end else begin
      bus.frame_err <= ferr_evt;
      bus.break_det <= brk_evt;
      if (done && (!bus.dout_valid || bus.dout_ready)) begin
        bus.dout       <= shreg;
        bus.dout_valid <= 1'b1;
      end else if (bus.dout_valid && bus.dout_ready) begin
        bus.dout_valid <= 1'b0;
      end
      if (done && bus.dout_valid && !bus.dout_ready)
        bus.overrun <= 1'b1;
      else if (bus.clr_err)
        bus.overrun <= 1'b0;
    end
  end
endmodule

// File: tb/tb_uart_rx.sv
// Directed bench for uart_rx at DIV=16 / HALF=8: a vector table of single frames
// plus hand-written glitch, long-break, overrun and mid-frame reset sequences.
module tb_uart_rx;
  logic       clk;
  logic       sys_resetn;
  logic       uart_rxp;
  logic [2:0] fsm_state;

  uart_rx_if bus ();

  uart_rx #(.CLK_FREQ(16), .BAUD(1)) dut (
    .clk        (clk),
    .sys_resetn (sys_resetn),
    .uart_rxp   (uart_rxp),
    .bus        (bus.master),
    .fsm_state  (fsm_state)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- monitor (cumulative counts, sampled on falling edge) ----------------
  int         valid_cnt = 0;
  int         ferr_cnt  = 0;
  int         brk_cnt   = 0;
  logic [7:0] last_dout = 8'h00;

  always @(negedge clk) begin
    if (bus.dout_valid) begin
      valid_cnt = valid_cnt + 1;
      last_dout = bus.dout;
    end
    if (bus.frame_err) ferr_cnt = ferr_cnt + 1;
    if (bus.break_det) brk_cnt = brk_cnt + 1;
  end

  // ---------------- scoreboard ----------------
  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
  endtask

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    uart_rxp = 1'b1;
    repeat (n) tick();
  endtask

  // Tick t of the frame is followed by DUT edge E(t+1); pulse_at raises dout_ready for one tick.
  task automatic send_frame(input logic [7:0] d, input logic stop, input int pulse_at);
    logic [9:0] bits;
    logic       ready_save;
    bits = {stop, d, 1'b0};
    ready_save = bus.dout_ready;
    for (int i = 0; i < 10; i++) begin
      uart_rxp = bits[i];
      for (int k = 0; k < 16; k++) begin
        if (i * 16 + k == pulse_at) bus.dout_ready = 1'b1;
        tick();
        if (i * 16 + k == pulse_at) bus.dout_ready = ready_save;
      end
    end
    uart_rxp = 1'b1;
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    logic [7:0] data;
    logic       stop;
    int         exp_valid;
    logic [7:0] exp_dout;
    int         exp_ferr;
    int         exp_brk;
  } vec_t;

  vec_t vecs[6];

  initial begin
    int bv, bf, bb;

    vecs[0] = '{data: 8'h55, stop: 1'b1, exp_valid: 1, exp_dout: 8'h55, exp_ferr: 0, exp_brk: 0};
    vecs[1] = '{data: 8'h3C, stop: 1'b0, exp_valid: 0, exp_dout: 8'h55, exp_ferr: 1, exp_brk: 0};
    vecs[2] = '{data: 8'h81, stop: 1'b1, exp_valid: 1, exp_dout: 8'h81, exp_ferr: 0, exp_brk: 0};
    vecs[3] = '{data: 8'h00, stop: 1'b0, exp_valid: 0, exp_dout: 8'h81, exp_ferr: 0, exp_brk: 1};
    vecs[4] = '{data: 8'hFF, stop: 1'b1, exp_valid: 1, exp_dout: 8'hFF, exp_ferr: 0, exp_brk: 0};
    vecs[5] = '{data: 8'hA6, stop: 1'b1, exp_valid: 1, exp_dout: 8'hA6, exp_ferr: 0, exp_brk: 0};

    sys_resetn     = 1'b0;
    uart_rxp       = 1'b1;
    bus.dout_ready = 1'b1;
    bus.clr_err    = 1'b0;
    repeat (3) tick();
    check("reset_dout", bus.dout, 8'h00);
    check("reset_valid", bus.dout_valid, 1'b0);
    check("reset_overrun", bus.overrun, 1'b0);
    check("reset_frame_err", bus.frame_err, 1'b0);
    check("reset_state", fsm_state, 3'd0);
    sys_resetn = 1'b1;
    idle(8);

    // table-driven single frames, dout_ready held high
    for (int v = 0; v < 6; v++) begin
      bv = valid_cnt; bf = ferr_cnt; bb = brk_cnt;
      send_frame(vecs[v].data, vecs[v].stop, -1);
      idle(32);
      check($sformatf("vec%0d_valid_cycles", v), valid_cnt - bv, vecs[v].exp_valid);
      check($sformatf("vec%0d_dout", v), bus.dout, vecs[v].exp_dout);
      check($sformatf("vec%0d_frame_err", v), ferr_cnt - bf, vecs[v].exp_ferr);
      check($sformatf("vec%0d_break", v), brk_cnt - bb, vecs[v].exp_brk);
      check($sformatf("vec%0d_overrun", v), bus.overrun, 1'b0);
    end

    // short low glitch rejected in START
    bv = valid_cnt;
    uart_rxp = 1'b0;
    repeat (5) tick();
    idle(30);
    check("glitch_no_valid", valid_cnt - bv, 0);
    check("glitch_state_idle", fsm_state, 3'd0);
    bv = valid_cnt;
    send_frame(8'hA3, 1'b1, -1);
    idle(32);
    check("after_glitch_valid", valid_cnt - bv, 1);
    check("after_glitch_dout", last_dout, 8'hA3);

    // line low for 12 bit times: one break pulse, no byte until the line is released
    bv = valid_cnt; bf = ferr_cnt; bb = brk_cnt;
    uart_rxp = 1'b0;
    repeat (12 * 16) tick();
    check("long_break_state_wait", fsm_state, 3'd4);
    check("long_break_no_valid", valid_cnt - bv, 0);
    idle(32);
    check("long_break_pulses", brk_cnt - bb, 1);
    check("long_break_no_ferr", ferr_cnt - bf, 0);
    bv = valid_cnt;
    send_frame(8'hFF, 1'b1, -1);
    idle(32);
    check("after_break_valid", valid_cnt - bv, 1);
    check("after_break_dout", last_dout, 8'hFF);

    // overrun: two bytes with no consumer
    bus.dout_ready = 1'b0;
    send_frame(8'h11, 1'b1, -1);
    idle(32);
    check("ovr_first_valid", bus.dout_valid, 1'b1);
    check("ovr_first_no_overrun", bus.overrun, 1'b0);
    send_frame(8'h22, 1'b1, -1);
    idle(32);
    check("ovr_dout_kept", bus.dout, 8'h11);
    check("ovr_set", bus.overrun, 1'b1);
    bus.clr_err = 1'b1;
    tick();
    bus.clr_err = 1'b0;
    check("ovr_cleared", bus.overrun, 1'b0);
    check("ovr_valid_still", bus.dout_valid, 1'b1);
    bus.dout_ready = 1'b1;
    tick();
    bus.dout_ready = 1'b0;
    check("ovr_handshake_clears", bus.dout_valid, 1'b0);

    // completion on the same edge as a handshake (stop sample edge is E155 -> tick 154)
    send_frame(8'h11, 1'b1, -1);
    idle(32);
    check("coinc_first_valid", bus.dout_valid, 1'b1);
    send_frame(8'h22, 1'b1, 154);
    idle(8);
    check("coinc_dout_new", bus.dout, 8'h22);
    check("coinc_valid_kept", bus.dout_valid, 1'b1);
    check("coinc_no_overrun", bus.overrun, 1'b0);

    // reset during data bit 4 of 0xF0 (0x22 still pending in the buffer)
    bv = valid_cnt;
    uart_rxp = 1'b0;
    repeat (16 * 5) tick();
    uart_rxp = 1'b1;
    repeat (6) tick();
    check("pre_reset_state_data", fsm_state, 3'd2);
    sys_resetn = 1'b0;
    #1;
    check("midreset_dout", bus.dout, 8'h00);
    check("midreset_valid", bus.dout_valid, 1'b0);
    check("midreset_state", fsm_state, 3'd0);
    check("midreset_ferr", bus.frame_err, 1'b0);
    check("midreset_brk", bus.break_det, 1'b0);
    uart_rxp = 1'b0;
    repeat (3) tick();
    sys_resetn = 1'b1;
    bv = valid_cnt;
    repeat (40) tick();
    check("low_after_reset_idle", fsm_state, 3'd0);
    idle(20);
    check("low_after_reset_no_valid", valid_cnt - bv, 0);
    bus.dout_ready = 1'b1;
    bv = valid_cnt;
    send_frame(8'h5A, 1'b1, -1);
    idle(32);
    check("after_reset_valid", valid_cnt - bv, 1);
    check("after_reset_dout", last_dout, 8'h5A);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
